banco_registradores_n: RTL and testbench
========================================

// Module: banco_registradores_n
// PURPOSE
// - Parametrised register file: DEPTH words of WIDTH bits, 1 write port, 2 read ports (A, B).
// - Generalises the single-bit level-sensitive storage element into edge-triggered, addressable multi-word storage.
// - Holds the 8-bit ALU operands and results: ports A/B feed the ALU inputs, and the write port takes the ALU result.
// PARAMETERS
// - WIDTH     8  bits per word (>=1).
// - DEPTH     8  number of words (>=2, need not be a power of two).
// - ADDR_W    $clog2(DEPTH)  address width, derived; do not override.
// - READ_REG  0  0 = combinational read; 1 = registered read, 1-cycle latency.
// - BYPASS    1  1 = same-cycle write data forwarded to a matching read port; 0 = read returns the old value.
// - ZERO_REG  0  1 = word 0 is hard-wired to zero, and writes to it are discarded.
// PORTS
// - clk      in   1       sole clock; every state changes on its rising edge.
// - reset    in   1       synchronous, active-high; clears all words and registered outputs.
// - we       in   1       write enable.
// - waddr    in   ADDR_W  write address.
// - wdata    in   WIDTH   write data.
// - raddr_a  in   ADDR_W  read address for port A.
// - rdata_a  out  WIDTH   read data for port A.
// - raddr_b  in   ADDR_W  read address for port B.
// - rdata_b  out  WIDTH   read data for port B.
// BEHAVIOUR
// - Reset: at the first rising clk edge with reset=1, all DEPTH words become 0.
//   - READ_REG=1: rdata_a and rdata_b are 0 from that edge on.
//   - READ_REG=0: the outputs show 0 because the words are 0.
// - Reset dominates we. A write presented in the same cycle as reset is lost.
// - Reset mid-sequence: any pending registered read is discarded; the next output after reset deasserts reflects the cleared array.
// - Write: on a rising edge with reset=0, we=1 and waddr<DEPTH, word[waddr] <= wdata. All other words hold.
// - Read, READ_REG=0: rdata_x = word[raddr_x] combinationally.
// - Read, READ_REG=1: rdata_x is sampled at the edge and valid the cycle after the address is presented.
// - Bypass (BYPASS=1): when we=1, waddr==raddr_x and the address is writable, the read returns wdata.
//   - READ_REG=0: wdata appears in the same cycle.
//   - READ_REG=1: wdata appears in the next cycle.
// - Bypass off (BYPASS=0): a colliding read returns the pre-write word. With READ_REG=0 the new value is visible after the edge.
// - Ports A and B are independent. raddr_a==raddr_b is legal, and both ports return identical data.
// - Out of range (addr>=DEPTH, possible when DEPTH is not a power of two):
//   - write: discarded, no side effects;
//   - read: returns 0;
//   - bypass never applies.
// - ZERO_REG=1: reading address 0 always returns 0, bypass included. Writes to 0 are discarded.
// - No internal state beyond the array and, when READ_REG=1, the two output registers. There is no FSM.
// - Outputs are never X after the first reset edge.
// STRUCTURE
// - Shared package pacote_ula_pkg holds:
//   - constant LARG_PALAVRA = 8, the default WIDTH;
//   - the address-width helper function used for ADDR_W.
// - Sub-module registrador_n (WIDTH, sync active-high reset, load enable) is instantiated once per word via a generate loop.
//   - With ZERO_REG=1, word 0 is a constant and is not instantiated.
// - Write decoder: one-hot load enables gated by we and the range check.
// - Read mux: one per port, with bypass compare and out-of-range/zero forcing, followed by an optional output register per port.
// TESTING
// - Run every scenario in all four READ_REG/BYPASS combinations, with DEPTH=8 and DEPTH=6.
// - T1 reset: write 0xFF to every word, then reset=1 for 1 cycle -> every address reads 0x00; the write in the reset cycle is lost.
// - T2 basic: write 0x3C@2 and 0xA5@5, read A=2, B=5 -> rdata_a=0x3C, rdata_b=0xA5.
//   - READ_REG=1: data valid the cycle after the address.
// - T3 collision: word3=0x11, then in one cycle we=1, waddr=3, wdata=0x77, raddr_a=3:
//   - BYPASS=1 -> rdata_a=0x77 (same cycle if READ_REG=0, next cycle if READ_REG=1);
//   - BYPASS=0 -> rdata_a=0x11 in the collision cycle, 0x77 afterwards.
// - T4 zero/range: ZERO_REG=1, write 0x55@0 -> reads 0x00. DEPTH=6: write 0x99@7 -> words 0..5 unchanged, read @7 -> 0x00.
// - T5 dual port: raddr_a=raddr_b=4 holding 0xC3 -> both 0xC3. Back-to-back writes 1,2,3,4 -> each reads back its value.
// - T6 random: 2000 cycles of random we/addr/data with 2% reset, checked against a scoreboard model of the array.

Source files
------------

// File: rtl/banco_registradores_n_pkg.sv
// Shared definitions for the ALU datapath: default word width and the
// address-width helper used to size register-file addresses.
package pacote_ula_pkg;

   localparam int LARG_PALAVRA = 8;

   // Never returns less than 1 so a 2-word file still gets a real address bit.
   function automatic int larg_endereco(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/banco_registradores_n_registrador_n.sv
// One WIDTH-bit storage word: synchronous active-high clear, load enable.
module registrador_n #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) q_d = d_i;
   end

   always_ff @(posedge clk) begin
      if (reset_i) q_q <= '0;
      else         q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/banco_registradores_n.sv
// DEPTH x WIDTH register file, one write port and two independent read
// ports with optional write-to-read forwarding and optional output registers.
module banco_registradores_n
   import pacote_ula_pkg::*;
#(
   parameter int WIDTH    = LARG_PALAVRA,
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = larg_endereco(DEPTH),
   parameter int READ_REG = 0,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [WIDTH-1:0]  rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_b
);

   logic [DEPTH-1:0][WIDTH-1:0] palavras;
   logic [1:0][ADDR_W-1:0]      raddr_v;
   logic [1:0][WIDTH-1:0]       rdata_v;

   assign raddr_v[0] = raddr_a;
   assign raddr_v[1] = raddr_b;
   assign rdata_a    = rdata_v[0];
   assign rdata_b    = rdata_v[1];

   // Out-of-range write addresses match no word, so they are dropped here.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_palavra
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
         assign palavras[gi] = '0;
      end else begin : g_reg
         logic carga;
         assign carga = we && (waddr == ADDR_W'(gi));
         registrador_n #(.WIDTH(WIDTH)) u_reg (
            .clk     (clk),
            .reset_i (reset),
            .load_i  (carga),
            .d_i     (wdata),
            .q_o     (palavras[gi])
         );
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_porta
      logic [WIDTH-1:0] rd_d;

      // Forwarding is suppressed under reset because that write never lands.
      always_comb begin
         rd_d = '0;
         if (int'(raddr_v[gi]) < DEPTH) begin
            rd_d = palavras[raddr_v[gi]];
            if (BYPASS != 0 && we && !reset && waddr == raddr_v[gi])
               rd_d = wdata;
         end
         if (ZERO_REG != 0 && raddr_v[gi] == '0) rd_d = '0;
      end

      if (READ_REG != 0) begin : g_reg_saida
         logic [WIDTH-1:0] rd_q;
         always_ff @(posedge clk) begin
            if (reset) rd_q <= '0;
            else       rd_q <= rd_d;
         end
         assign rdata_v[gi] = rd_q;
      end else begin : g_comb_saida
         assign rdata_v[gi] = rd_d;
      end
   end

endmodule

// File: tb/tb_banco_registradores_n.sv
// Scoreboard bench: sixteen register-file configurations share one stimulus
// stream; each has its own array model, expected-value queues and monitor.
module tb_banco_registradores_n;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       we = 1'b0;
   logic [2:0] waddr = '0;
   logic [7:0] wdata = '0;
   logic [2:0] raddr_a = '0;
   logic [2:0] raddr_b = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Configuration index bits: 0 = READ_REG, 1 = BYPASS, 2 = DEPTH 6, 3 = ZERO_REG.
   for (genvar gi = 0; gi < 16; gi++) begin : g_cfg
      localparam int RR = gi & 1;
      localparam int BP = (gi >> 1) & 1;
      localparam int DP = ((gi >> 2) & 1) ? 6 : 8;
      localparam int ZR = (gi >> 3) & 1;

      logic [7:0] out_a;
      logic [7:0] out_b;
      logic [7:0] mem [8];
      logic [7:0] qa [$];
      logic [7:0] qb [$];
      bit         started = 1'b0;

      banco_registradores_n #(
         .WIDTH(8), .DEPTH(DP), .READ_REG(RR), .BYPASS(BP), .ZERO_REG(ZR)
      ) u_dut (
         .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
         .raddr_a(raddr_a), .rdata_a(out_a), .raddr_b(raddr_b), .rdata_b(out_b)
      );

      function automatic bit writable(input logic [2:0] a);
         return (int'(a) < DP) && !(ZR != 0 && a == 3'd0);
      endfunction

      function automatic logic [7:0] ref_read(input logic [2:0] a);
         if (!writable(a)) return 8'h00;
         if (BP != 0 && we && !reset && waddr == a) return wdata;
         return mem[a];
      endfunction

      initial begin : model_edge
         forever begin
            @(posedge clk);
            if (RR != 0 && (started || reset)) begin
               qa.push_back(reset ? 8'h00 : ref_read(raddr_a));
               qb.push_back(reset ? 8'h00 : ref_read(raddr_b));
            end
            if (reset) begin
               for (int i = 0; i < 8; i++) mem[i] = 8'h00;
               started = 1'b1;
            end else if (we && writable(waddr)) begin
               mem[waddr] = wdata;
            end
         end
      end

      if (RR == 0) begin : g_comb_model
         initial begin
            forever begin
               @(negedge clk);
               if (started) begin
                  qa.push_back(ref_read(raddr_a));
                  qb.push_back(ref_read(raddr_b));
               end
            end
         end
      end

      initial begin : monitor
         logic [7:0] ea;
         logic [7:0] eb;
         forever begin
            if (RR != 0) @(posedge clk);
            else         @(negedge clk);
            #1;
            while (qa.size() > 0 && qb.size() > 0) begin
               ea = qa.pop_front();
               eb = qb.pop_front();
               checks++;
               if (out_a !== ea) begin
                  errors++;
                  $display("FAIL cfg%0d rdata_a t=%0t addr=%0d got=%h exp=%h",
                           gi, $time, raddr_a, out_a, ea);
               end
               checks++;
               if (out_b !== eb) begin
                  errors++;
                  $display("FAIL cfg%0d rdata_b t=%0t addr=%0d got=%h exp=%h",
                           gi, $time, raddr_b, out_b, eb);
               end
            end
         end
      end
   end

   task automatic cyc(input logic r, input logic w, input logic [2:0] wa,
                      input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb);
      reset   = r;
      we      = w;
      waddr   = wa;
      wdata   = wd;
      raddr_a = ra;
      raddr_b = rb;
      @(posedge clk);
      #2;
   endtask

   initial begin : stimulus
      logic [2:0] a3;
      @(posedge clk);
      #2;
      cyc(1, 0, 0, 8'h00, 0, 0);
      // T1: fill with FF, reset with a write pending, read everything back
      for (int i = 0; i < 8; i++) cyc(0, 1, 3'(i), 8'hFF, 3'(i), 3'(7 - i));
      cyc(1, 1, 1, 8'hFF, 1, 2);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 3'(i), 3'(7 - i));
      // T2: basic write/read
      cyc(0, 1, 2, 8'h3C, 0, 0);
      cyc(0, 1, 5, 8'hA5, 0, 0);
      cyc(0, 0, 0, 8'h00, 2, 5);
      cyc(0, 0, 0, 8'h00, 2, 5);
      // T3: read/write collision on word 3
      cyc(0, 1, 3, 8'h11, 0, 0);
      cyc(0, 1, 3, 8'h77, 3, 3);
      cyc(0, 0, 0, 8'h00, 3, 3);
      cyc(0, 0, 0, 8'h00, 3, 3);
      // T4: word 0 and out-of-range address
      cyc(0, 1, 0, 8'h55, 0, 0);
      cyc(0, 0, 0, 8'h00, 0, 0);
      cyc(0, 1, 7, 8'h99, 7, 6);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 3'(i), 7);
      // T5: dual port on one address, back-to-back writes
      cyc(0, 1, 4, 8'hC3, 0, 0);
      cyc(0, 0, 0, 8'h00, 4, 4);
      cyc(0, 0, 0, 8'h00, 4, 4);
      for (int i = 1; i <= 4; i++) cyc(0, 1, 3'(i), 8'(i), 3'(i), 3'(i - 1));
      for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 8'h00, 3'(i), 3'(5 - i));
      // T6: random traffic with occasional reset
      for (int n = 0; n < 2000; n++) begin
         a3 = 3'($urandom_range(7));
         cyc(($urandom_range(99) < 2), 1'($urandom_range(1)), a3, 8'($urandom),
             ($urandom_range(3) == 0) ? a3 : 3'($urandom_range(7)),
             3'($urandom_range(7)));
      end
      cyc(0, 0, 0, 8'h00, 0, 0);
      cyc(0, 0, 0, 8'h00, 0, 0);
      @(negedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
